// File: rtl/fir_pkg.sv
// Shared definitions for the complex interpolating FIR: prototype coefficients,
// output quantisation shift and the control FSM state encoding.
package fir_pkg;

    localparam int QUANT_BITS = 10;
    localparam int H_LEN      = 16;

    // Prototype filter h[0..H_LEN-1]; TAP_COUNT of the filter must not exceed H_LEN.
    localparam int H_COEF [H_LEN] = '{
        1, 2048, -300, 512, 1024, -77, 900, 33,
        -1500, 250, 60, -8, 700, 4000, -2, 127
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_mac_lane.sv
// One rail of the interpolator datapath: MULT_PER_CYCLE signed multipliers
// summed into a 2*DATA_WIDTH accumulator that restarts when clr is high.
module fir_mac_lane #(
    parameter int DATA_WIDTH     = 32,
    parameter int MULT_PER_CYCLE = 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      en,
    input  logic                                      clr,
    input  logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] x_vec,
    input  logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] h_vec,
    output logic signed [2*DATA_WIDTH-1:0]            acc_next
);

    logic signed [2*DATA_WIDTH-1:0] prod [MULT_PER_CYCLE];
    logic signed [2*DATA_WIDTH-1:0] acc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MULT_PER_CYCLE; gi++) begin : g_mult
            assign prod[gi] = $signed(x_vec[gi]) * $signed(h_vec[gi]);
        end
    endgenerate

    // acc_next is exported so the top can capture the finished sum on the last MAC step.
    always_comb begin
        acc_next = clr ? '0 : acc_reg;
        for (int i = 0; i < MULT_PER_CYCLE; i++) begin
            acc_next = acc_next + prod[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/fir_complex_interp.sv
// Polyphase complex (I/Q) interpolating FIR: L outputs per accepted sample.
// Optional build macro FIR_INTERP_ROUND_EN: round half up before the output shift.
module fir_complex_interp
    import fir_pkg::*;
#(
    parameter int TAP_COUNT      = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MULT_PER_CYCLE = 2,
    parameter int INTERP_FACTOR  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] Iin,
    input  logic signed [DATA_WIDTH-1:0] Qin,
    input  logic                         newDataAvailible,
    output logic                         inReady,
    output logic signed [DATA_WIDTH-1:0] Iout,
    output logic signed [DATA_WIDTH-1:0] Qout,
    output logic                         Done
);

    localparam int P     = TAP_COUNT / INTERP_FACTOR;
    localparam int STEPS = (P + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
    localparam int PH_W  = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam int ST_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

    fir_state_t      state_reg, state_next;
    logic [PH_W-1:0] phase_reg, phase_next;
    logic [ST_W-1:0] step_reg, step_next;
    logic            accept, mac_en, mac_clr, last_step, last_phase;

    logic signed [DATA_WIDTH-1:0] xi_reg [P];
    logic signed [DATA_WIDTH-1:0] xq_reg [P];

    logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] lane_xi, lane_xq, lane_h;
    logic signed [2*DATA_WIDTH-1:0]            acc_i_next, acc_q_next;
    logic signed [DATA_WIDTH-1:0]              iout_reg, qout_reg;
    logic                                      done_reg;

    assign accept     = inReady && newDataAvailible;
    assign last_step  = (step_reg == ST_W'(STEPS - 1));
    assign last_phase = (phase_reg == PH_W'(INTERP_FACTOR - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        step_next  = step_reg;
        inReady    = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        case (state_reg)
            IDLE: begin
                inReady = 1'b1;
                if (newDataAvailible) begin
                    state_next = MAC;
                    phase_next = '0;
                    step_next  = '0;
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (step_reg == '0);
                if (last_step) begin
                    state_next = EMIT;
                end else begin
                    step_next = step_reg + 1'b1;
                end
            end
            EMIT: begin
                step_next = '0;
                if (last_phase) begin
                    state_next = IDLE;
                end else begin
                    state_next = MAC;
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Delay line: tap 0 is the newest sample, tap P-1 the oldest.
    genvar gi, gc, gp;
    generate
        for (gi = 0; gi < P; gi++) begin : g_tap
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    xi_reg[gi] <= '0;
                    xq_reg[gi] <= '0;
                end else if (accept) begin
                    if (gi == 0) begin
                        xi_reg[gi] <= Iin;
                        xq_reg[gi] <= Qin;
                    end else begin
                        xi_reg[gi] <= xi_reg[(gi > 0) ? gi - 1 : 0];
                        xq_reg[gi] <= xq_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end

        // Multiplier gi handles tap k = step*MULT_PER_CYCLE + gi; taps beyond P are zero-padded.
        for (gi = 0; gi < MULT_PER_CYCLE; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] xi_sel [STEPS];
            logic [DATA_WIDTH-1:0] xq_sel [STEPS];
            logic [DATA_WIDTH-1:0] h_sel  [INTERP_FACTOR][STEPS];
            for (gc = 0; gc < STEPS; gc++) begin : g_step
                localparam int TAP = gc * MULT_PER_CYCLE + gi;
                if (TAP < P) begin : g_live
                    assign xi_sel[gc] = xi_reg[TAP];
                    assign xq_sel[gc] = xq_reg[TAP];
                    for (gp = 0; gp < INTERP_FACTOR; gp++) begin : g_ph
                        assign h_sel[gp][gc] = DATA_WIDTH'(H_COEF[gp + TAP * INTERP_FACTOR]);
                    end
                end else begin : g_pad
                    assign xi_sel[gc] = '0;
                    assign xq_sel[gc] = '0;
                    for (gp = 0; gp < INTERP_FACTOR; gp++) begin : g_ph
                        assign h_sel[gp][gc] = '0;
                    end
                end
            end
            assign lane_xi[gi] = xi_sel[step_reg];
            assign lane_xq[gi] = xq_sel[step_reg];
            assign lane_h[gi]  = h_sel[phase_reg][step_reg];
        end
    endgenerate

    fir_mac_lane #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MULT_PER_CYCLE (MULT_PER_CYCLE)
    ) u_lane_i (
        .clock    (clock),
        .reset    (reset),
        .en       (mac_en),
        .clr      (mac_clr),
        .x_vec    (lane_xi),
        .h_vec    (lane_h),
        .acc_next (acc_i_next)
    );

    fir_mac_lane #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MULT_PER_CYCLE (MULT_PER_CYCLE)
    ) u_lane_q (
        .clock    (clock),
        .reset    (reset),
        .en       (mac_en),
        .clr      (mac_clr),
        .x_vec    (lane_xq),
        .h_vec    (lane_h),
        .acc_next (acc_q_next)
    );

    function automatic logic signed [DATA_WIDTH-1:0] quantize(
        input logic signed [2*DATA_WIDTH-1:0] acc
    );
        logic signed [2*DATA_WIDTH-1:0] r;
`ifdef FIR_INTERP_ROUND_EN
        r = acc + {{(2*DATA_WIDTH-QUANT_BITS){1'b0}}, 1'b1, {(QUANT_BITS-1){1'b0}}};
`else
        r = acc;
`endif
        r = r >>> QUANT_BITS;
        return r[DATA_WIDTH-1:0];
    endfunction

    // Outputs load on the final MAC step so they are valid in the EMIT cycle and hold afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_reg <= 1'b0;
            iout_reg <= '0;
            qout_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == MAC && last_step) begin
                done_reg <= 1'b1;
                iout_reg <= quantize(acc_i_next);
                qout_reg <= quantize(acc_q_next);
            end
        end
    end

    assign Done = done_reg;
    assign Iout = iout_reg;
    assign Qout = qout_reg;

endmodule

// File: tb/tb_fir_complex_interp.sv
// Self-checking bench for fir_complex_interp: directed impulse/rounding/wrap cases
// plus random samples checked against a direct polyphase-sum reference model.
module tb_fir_complex_interp;

    localparam int TAPS = 16;
    localparam int W    = 32;
    localparam int M    = 2;
    localparam int L    = 4;
    localparam int P    = TAPS / L;
    localparam int C    = (P + M - 1) / M + 1;
    localparam int SPAN = L * C;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic signed [W-1:0] Iin = '0;
    logic signed [W-1:0] Qin = '0;
    logic                newDataAvailible = 1'b0;
    logic                inReady;
    logic                Done;
    logic signed [W-1:0] Iout;
    logic signed [W-1:0] Qout;

    int vec_cnt = 0;
    int err_cnt = 0;

    int h_tab [TAPS] = '{
        1, 2048, -300, 512, 1024, -77, 900, 33,
        -1500, 250, 60, -8, 700, 4000, -2, 127
    };

    longint      hist_i [P];
    longint      hist_q [P];
    logic [W-1:0] out_i [L];
    logic [W-1:0] out_q [L];

    always #5 clock = ~clock;

    fir_complex_interp #(
        .TAP_COUNT      (TAPS),
        .DATA_WIDTH     (W),
        .MULT_PER_CYCLE (M),
        .INTERP_FACTOR  (L)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .Iin              (Iin),
        .Qin              (Qin),
        .newDataAvailible (newDataAvailible),
        .inReady          (inReady),
        .Iout             (Iout),
        .Qout             (Qout),
        .Done             (Done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int k = 0; k < P; k++) begin
            hist_i[k] = 0;
            hist_q[k] = 0;
        end
    endfunction

    function automatic void model_push(input logic signed [W-1:0] si, input logic signed [W-1:0] sq);
        for (int k = P - 1; k > 0; k--) begin
            hist_i[k] = hist_i[k-1];
            hist_q[k] = hist_q[k-1];
        end
        hist_i[0] = longint'(si);
        hist_q[0] = longint'(sq);
    endfunction

    // y_p = sum_k h[p + k*L] * x[n-k], then >>> 10 (optionally +512 first), low W bits kept.
    function automatic logic [W-1:0] model_y(input int p, input bit use_q);
        longint acc;
        acc = 0;
        for (int k = 0; k < P; k++) begin
            acc = acc + longint'(h_tab[p + k*L]) * (use_q ? hist_q[k] : hist_i[k]);
        end
`ifdef FIR_INTERP_ROUND_EN
        acc = acc + 512;
`endif
        acc = acc >>> 10;
        return acc[W-1:0];
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset = 1'b0;
        newDataAvailible = 1'b0;
        Iin = '0;
        Qin = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_clear();
    endtask

    // Called at a negedge with inReady high; accept happens at the next posedge (cycle 0).
    // With hold=1 newDataAvailible stays high carrying hold values through the busy window.
    task automatic drive_sample(input logic signed [W-1:0] si, input logic signed [W-1:0] sq,
                                input bit hold,
                                input logic signed [W-1:0] hold_i, input logic signed [W-1:0] hold_q);
        int   pulses;
        logic exp_done;
        logic exp_rdy;
        pulses = 0;
        vec_cnt++;
        if (inReady !== 1'b1) begin
            err_cnt++;
            $display("FAIL accept_ready: inReady=%b expected 1", inReady);
        end
        Iin = si;
        Qin = sq;
        newDataAvailible = 1'b1;
        model_push(si, sq);
        @(posedge clock);
        #1;
        if (hold) begin
            Iin = hold_i;
            Qin = hold_q;
        end else begin
            newDataAvailible = 1'b0;
            Iin = $urandom;
            Qin = $urandom;
        end
        for (int k = 1; k <= SPAN + 1; k++) begin
            @(negedge clock);
            exp_done = ((k % C) == 0) && (k <= SPAN);
            exp_rdy  = (k == SPAN + 1);
            vec_cnt++;
            if (Done !== exp_done || inReady !== exp_rdy) begin
                err_cnt++;
                $display("FAIL timing cycle %0d: Done=%b inReady=%b expected Done=%b inReady=%b",
                         k, Done, inReady, exp_done, exp_rdy);
            end
            if (Done === 1'b1 && pulses < L) begin
                out_i[pulses] = Iout;
                out_q[pulses] = Qout;
                pulses++;
            end
        end
        vec_cnt++;
        if (pulses != L) begin
            err_cnt++;
            $display("FAIL pulse_count: got %0d Done pulses expected %0d", pulses, L);
        end
        $display("txn in I=%0d Q=%0d hold=%0d -> I=%0d,%0d,%0d,%0d Q=%0d,%0d,%0d,%0d",
                 si, sq, hold, $signed(out_i[0]), $signed(out_i[1]), $signed(out_i[2]),
                 $signed(out_i[3]), $signed(out_q[0]), $signed(out_q[1]), $signed(out_q[2]),
                 $signed(out_q[3]));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        vec_cnt++;
        if (Done !== 1'b0 || Iout !== '0 || Qout !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: Done=%b Iout=%0d Qout=%0d expected 0/0/0", Done, Iout, Qout);
        end
        reset = 1'b1;
        model_clear();
        #1;
        vec_cnt++;
        if (inReady !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready: inReady=%b expected 1", inReady);
        end
    endtask

    task automatic run_impulse_check(input string tag);
        logic [W-1:0] exp_i;
        logic [W-1:0] exp_q;
        for (int j = 0; j < P; j++) begin
            if (j == 0) drive_sample(32'sd1024, -32'sd1024, 1'b0, '0, '0);
            else        drive_sample('0, '0, 1'b0, '0, '0);
            for (int p = 0; p < L; p++) begin
                exp_i = W'(h_tab[j*L + p]);
                exp_q = W'(-h_tab[j*L + p]);
                vec_cnt++;
                if (out_i[p] !== exp_i || out_q[p] !== exp_q) begin
                    err_cnt++;
                    $display("FAIL %s h[%0d]: Iout=%0d Qout=%0d expected %0d/%0d", tag, j*L + p,
                             $signed(out_i[p]), $signed(out_q[p]), $signed(exp_i), $signed(exp_q));
                end
            end
        end
    endtask

    task automatic test_impulse();
        run_impulse_check("impulse");
    endtask

    task automatic test_rounding();
        logic [W-1:0] exp_i;
        logic [W-1:0] exp_q;
        do_reset();
        drive_sample(32'sd512, -32'sd512, 1'b0, '0, '0);
`ifdef FIR_INTERP_ROUND_EN
        exp_i = 32'd1;
        exp_q = 32'd0;
`else
        exp_i = 32'd0;
        exp_q = 32'hFFFF_FFFF;
`endif
        vec_cnt++;
        if (out_i[0] !== exp_i || out_q[0] !== exp_q) begin
            err_cnt++;
            $display("FAIL rounding: Iout=%0d Qout=%0d expected %0d/%0d",
                     $signed(out_i[0]), $signed(out_q[0]), $signed(exp_i), $signed(exp_q));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive_sample(32'sh7FFF_FFFF, 32'sh8000_0000, 1'b0, '0, '0);
        // 2048 * (2^31-1) >>> 10 = 2^32-2 and 2048 * -2^31 >>> 10 = -2^32: both wrap.
        vec_cnt++;
        if (out_i[1] !== 32'hFFFF_FFFE || out_q[1] !== 32'h0000_0000) begin
            err_cnt++;
            $display("FAIL wrap: Iout=%h Qout=%h expected fffffffe/00000000", out_i[1], out_q[1]);
        end
        for (int p = 0; p < L; p++) begin
            vec_cnt++;
            if (out_i[p] !== model_y(p, 1'b0) || out_q[p] !== model_y(p, 1'b1)) begin
                err_cnt++;
                $display("FAIL wrap_model p%0d: Iout=%h Qout=%h expected %h/%h", p,
                         out_i[p], out_q[p], model_y(p, 1'b0), model_y(p, 1'b1));
            end
        end
    endtask

    // newDataAvailible held high: accepts at cycles 0, 13, 26 and the stall value 5000 is never used.
    task automatic test_cadence_stall();
        logic signed [W-1:0] si;
        logic signed [W-1:0] sq;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            si = W'(int'($urandom_range(0, 60000)) - 30000);
            sq = W'(int'($urandom_range(0, 60000)) - 30000);
            drive_sample(si, sq, 1'b1, 32'sd5000, -32'sd5000);
            for (int p = 0; p < L; p++) begin
                vec_cnt++;
                if (out_i[p] !== model_y(p, 1'b0) || out_q[p] !== model_y(p, 1'b1)) begin
                    err_cnt++;
                    $display("FAIL stall n%0d p%0d: Iout=%0d Qout=%0d expected %0d/%0d", n, p,
                             $signed(out_i[p]), $signed(out_q[p]),
                             $signed(model_y(p, 1'b0)), $signed(model_y(p, 1'b1)));
                end
            end
        end
        newDataAvailible = 1'b0;
    endtask

    task automatic test_random();
        logic signed [W-1:0] si;
        logic signed [W-1:0] sq;
        bit hold;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                si = $urandom;
                sq = $urandom;
            end else begin
                si = W'(int'($urandom_range(0, 200000)) - 100000);
                sq = W'(int'($urandom_range(0, 200000)) - 100000);
            end
            hold = 1'($urandom_range(0, 1));
            drive_sample(si, sq, hold, $urandom, $urandom);
            for (int p = 0; p < L; p++) begin
                vec_cnt++;
                if (out_i[p] !== model_y(p, 1'b0) || out_q[p] !== model_y(p, 1'b1)) begin
                    err_cnt++;
                    $display("FAIL random n%0d p%0d: Iout=%h Qout=%h expected %h/%h", n, p,
                             out_i[p], out_q[p], model_y(p, 1'b0), model_y(p, 1'b1));
                end
            end
        end
        newDataAvailible = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        Iin = 32'sd795648;
        Qin = -32'sd795648;
        newDataAvailible = 1'b1;
        @(posedge clock);
        #1;
        newDataAvailible = 1'b0;
        repeat (5) @(negedge clock);
        vec_cnt++;
        if (Iout !== 32'sd777 || Qout !== -32'sd777) begin
            err_cnt++;
            $display("FAIL mid_pre: Iout=%0d Qout=%0d expected 777/-777", Iout, Qout);
        end
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (Done !== 1'b0 || Iout !== '0 || Qout !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset: Done=%b Iout=%0d Qout=%0d expected 0/0/0", Done, Iout, Qout);
        end
        @(negedge clock);
        vec_cnt++;
        if (Done !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_no_done: Done=%b expected 0", Done);
        end
        reset = 1'b1;
        model_clear();
        run_impulse_check("after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_wrap();
        test_cadence_stall();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fir_complex_interp.md
FIR_COMPLEX_INTERP -- requirements
Module: fir_complex_interp

Interface
REQ-001 SHALL have parameter TAP_COUNT, default 16: total prototype filter taps; must be a multiple of INTERP_FACTOR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: signed width of I/Q samples and coefficients.
REQ-003 SHALL have parameter MULT_PER_CYCLE, default 2: multiplies per cycle per rail.
REQ-004 SHALL have parameter INTERP_FACTOR, default 4: outputs produced per accepted input (L).
REQ-005 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports Iin, Qin  in  DATA_WIDTH  signed input sample, Q10 fixed point.
REQ-008 SHALL have port newDataAvailible  in  1  input sample valid.
REQ-009 SHALL have port inReady  out  1  block can accept a sample this cycle.
REQ-010 SHALL have ports Iout, Qout  out  DATA_WIDTH  signed interpolated output sample.
REQ-011 SHALL have port Done  out  1  one-cycle pulse; Iout/Qout valid in that cycle.

Function
REQ-012 SHALL accept a sample on a rising edge where newDataAvailible and inReady are both 1; newDataAvailible is ignored when inReady is 0.
REQ-013 SHALL, on accept, shift (Iin,Qin) into a delay line of depth P = TAP_COUNT/INTERP_FACTOR; the oldest entry is discarded.
REQ-014 SHALL use FSM states IDLE (inReady=1), MAC, EMIT; IDLE->MAC on accept; MAC->EMIT after ceil(P/MULT_PER_CYCLE) cycles; EMIT->MAC for the next phase; EMIT->IDLE after phase L-1.
REQ-015 SHALL compute, for phase p = 0..L-1, y_p = sum over k=0..P-1 of h[p + k*L] * x[n-k], separately for I and Q using the same real coefficients.
REQ-016 SHALL use signed 2*DATA_WIDTH products and accumulators; the accumulator clears at the start of each phase.
REQ-017 SHALL output Iout/Qout = accumulator >>> 10, truncated to DATA_WIDTH with wrap and no saturation.
REQ-018 SHALL pulse Done once per EMIT; Iout/Qout hold their last value between pulses.
REQ-019 Timing, with accept in cycle 0 and C = ceil(P/MULT_PER_CYCLE)+1: Done SHALL be high in cycles C, 2C, ..., L*C, and inReady SHALL return high in cycle L*C+1.
REQ-020 For the default parameters, Done SHALL be high in cycles 3, 6, 9 and 12, and inReady SHALL be high again in cycle 13.
REQ-021 SHALL use zero-valued history entries until P samples have been accepted.

Reset
REQ-022 SHALL, when reset is low, asynchronously clear the delay line, accumulators and phase/MAC counters, enter IDLE, and drive Iout=0, Qout=0, Done=0, inReady=1 (or inReady=0 while reset is held).
REQ-023 SHALL abandon any in-progress phase on reset mid-operation, with no partial Done emitted.
REQ-024 SHALL make the first accept possible on the first rising edge after reset deasserts.

Configuration
REQ-025 With FIR_INTERP_ROUND_EN defined, the block SHALL add 2^9 to the accumulator before the >>>10 shift (round half up).
REQ-026 Without FIR_INTERP_ROUND_EN, the block SHALL truncate toward negative infinity; all timing is identical in both builds.

Structure
REQ-027 SHALL take the coefficient array h[0..TAP_COUNT-1], QUANT_BITS=10, and the FSM state enum from shared package fir_pkg.
REQ-028 SHALL instantiate a sub-module fir_mac_lane once for I and once for Q (MULT_PER_CYCLE multipliers plus accumulator); control stays in the top level.

Verification
REQ-029 Impulse: after reset, accept Iin=1024, Qin=-1024, then zeros -> the Iout sequence over successive Done pulses SHALL be h[0..15] and Qout SHALL be -h[0..15].
REQ-030 Cadence: hold newDataAvailible=1 continuously -> Done in cycles 3, 6, 9, 12, accepts in cycles 0, 13, 26, with exactly 4 Done pulses per accept.
REQ-031 Stall: assert newDataAvailible in cycles 1-12 with Iin=5000 -> not accepted until cycle 13, and the cycle-13 value is what is used.
REQ-032 Reset mid-operation: assert reset in cycle 5 -> Done=0 and Iout=Qout=0 immediately; the next impulse reproduces the REQ-029 output.
REQ-033 Rounding: with h[0]=1 and Iin=512 -> first Iout=1 with FIR_INTERP_ROUND_EN defined, and 0 without it.
REQ-034 Wrap: Iin=32'h7FFFFFFF with h[0]=2048 -> Iout equals (product >>> 10) truncated to 32 bits, with no saturation.
